// File: rtl/pll_reset_sequencer_pkg.sv
// pll_seq_pkg: shared types and constants for the PLL reset sequencer.
//   seqState_t      FILTER -> RELEASE -> RUN sequencing states
//   LOSS_CNT_W      width of the saturating lock-loss counter
//   DEF_*           default lock filter length and inter-stage gap
package pll_seq_pkg;
  typedef enum logic [1:0] {FILTER, RELEASE, RUN} seqState_t;
  localparam int LOSS_CNT_W = 8;
  localparam int DEF_LOCK_FILTER = 1024;
  localparam int DEF_STAGE_GAP = 16;
endpackage

// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: lock input / reset output bundle of the PLL reset sequencer.
//   pll_locked       async PLL LOCK flag             (master -> slave)
//   lost_clear       pulse clearing lock_lost        (master -> slave)
//   reset_out        active-high per-unit resets     (slave -> master)
//   ready            all resets released             (slave -> master)
//   lock_lost        sticky lock-loss flag           (slave -> master)
//   lock_loss_count  saturating lock-loss count      (slave -> master)
interface pll_reset_sequencer_if #(parameter int NUM_STAGES = 3);
  import pll_seq_pkg::*;
  logic pll_locked;
  logic lost_clear;
  logic [NUM_STAGES-1:0] reset_out;
  logic ready;
  logic lock_lost;
  logic [LOSS_CNT_W-1:0] lock_loss_count;
  modport master(output pll_locked, lost_clear, input reset_out, ready, lock_lost, lock_loss_count);
  modport slave(input pll_locked, lost_clear, output reset_out, ready, lock_lost, lock_loss_count);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit flag.
//   clock  destination clock
//   reset  asynchronous active-high reset, both flops to 0
//   d      asynchronous input
//   q      synchronised output, two edges after d
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clock or posedge reset)
    if (reset) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: filters PLL lock and releases per-unit resets in order with gaps.
//   clock  PLL-derived clock, the only clock
//   reset  asynchronous active-high reset
//   bus    slave side of pll_reset_sequencer_if (pll_locked, lost_clear in;
//          reset_out, ready, lock_lost, lock_loss_count out)
// Build option: define LOCK_LOSS_COUNT_EN to build the saturating lock-loss counter;
// otherwise lock_loss_count reads 0.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int STAGE_GAP   = DEF_STAGE_GAP,
  parameter int CNT_W       = 16
) (
  input logic clock,
  input logic reset,
  pll_reset_sequencer_if.slave bus
);
  localparam int IDX_W = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  logic lockSync;
  seqState_t state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [IDX_W-1:0] stage, stageNext;
  logic [NUM_STAGES-1:0] resetOut, resetOutNext;
  logic lockLost;
  logic lossEvent;

  sync_2ff lockSyncInst (.clock(clock), .reset(reset), .d(bus.pll_locked), .q(lockSync));

  // stage is the index of the next reset bit to release while in RELEASE.
  // FILTER compares before incrementing so release needs LOCK_FILTER+1 high samples;
  // RELEASE compares after incrementing so bits are exactly STAGE_GAP edges apart.
  always_comb begin
    stateNext = state;
    cntNext = cnt;
    stageNext = stage;
    resetOutNext = resetOut;
    lossEvent = 1'b0;
    if (!lockSync) begin
      stateNext = FILTER;
      cntNext = '0;
      stageNext = '0;
      resetOutNext = '1;
      lossEvent = state != FILTER;
    end else begin
      case (state)
        FILTER:
          if (cnt == CNT_W'(LOCK_FILTER)) begin
            resetOutNext[0] = 1'b0;
            cntNext = '0;
            stageNext = IDX_W'(1);
            stateNext = NUM_STAGES == 1 ? RUN : RELEASE;
          end else cntNext = cnt + CNT_W'(1);
        RELEASE:
          if (cnt + CNT_W'(1) == CNT_W'(STAGE_GAP)) begin
            resetOutNext[stage] = 1'b0;
            cntNext = '0;
            stageNext = stage + IDX_W'(1);
            stateNext = stage == IDX_W'(NUM_STAGES - 1) ? RUN : RELEASE;
          end else cntNext = cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= FILTER;
      cnt <= '0;
      stage <= '0;
      resetOut <= '1;
      lockLost <= 1'b0;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
      stage <= stageNext;
      resetOut <= resetOutNext;
      lockLost <= lossEvent | (lockLost & ~bus.lost_clear);
    end

`ifdef LOCK_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] lossCnt;
  always_ff @(posedge clock or posedge reset)
    if (reset) lossCnt <= '0;
    else if (lossEvent && lossCnt != '1) lossCnt <= lossCnt + LOSS_CNT_W'(1);
  assign bus.lock_loss_count = lossCnt;
`else
  assign bus.lock_loss_count = '0;
`endif

  assign bus.reset_out = resetOut;
  assign bus.ready = ~|resetOut;
  assign bus.lock_lost = lockLost;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scoreboard bench for pll_reset_sequencer against a run-length model.
module tb_pll_reset_sequencer;
  localparam int NS = 3;
  localparam int LF = 8;
  localparam int SG = 4;
  typedef struct packed {
    logic [NS-1:0] ro;
    logic rdy;
    logic lost;
    logic [7:0] cnt;
  } obs_t;
  localparam obs_t RST_OBS = '{ro: '1, rdy: 1'b0, lost: 1'b0, cnt: 8'd0};

  logic clock = 1'b0;
  logic reset = 1'b1;
  pll_reset_sequencer_if #(.NUM_STAGES(NS)) bus ();
  pll_reset_sequencer #(.NUM_STAGES(NS), .LOCK_FILTER(LF), .STAGE_GAP(SG), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  obs_t expq[$];
  bit hist[$];
  int run;
  bit mLost;
  int mCnt;

  function automatic obs_t observed();
    return '{ro: bus.reset_out, rdy: bus.ready, lost: bus.lock_lost, cnt: bus.lock_loss_count};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got reset_out=%b ready=%b lock_lost=%b count=%0d, required reset_out=%b ready=%b lock_lost=%b count=%0d",
               name, $time, got.ro, got.rdy, got.lost, got.cnt, exp.ro, exp.rdy, exp.lost, exp.cnt);
    end
  endtask

  // run = consecutive edges with synchronised lock high; stage k is free once
  // run reaches LF+1+k*SG, and a drop counts as a loss once stage 0 was free.
  function automatic obs_t expect_now();
    obs_t e;
    for (int k = 0; k < NS; k++) e.ro[k] = run < LF + 1 + k * SG;
    e.rdy = run >= LF + 1 + (NS - 1) * SG;
    e.lost = mLost;
    e.cnt = 8'(mCnt);
    return e;
  endfunction

  task automatic model_reset();
    hist.delete();
    run = 0;
    mLost = 0;
    mCnt = 0;
  endtask

  task automatic step(input bit lk, input bit clr);
    bit ls, recorded;
    bus.pll_locked = lk;
    bus.lost_clear = clr;
    @(posedge clock);
    hist.push_back(lk);
    ls = hist.size() >= 3 ? hist[hist.size() - 3] : 1'b0;
    if (hist.size() > 3) void'(hist.pop_front());
    recorded = !ls && run >= LF + 1;
    run = ls ? (run < 100000 ? run + 1 : run) : 0;
    mLost = recorded ? 1'b1 : (clr ? 1'b0 : mLost);
`ifdef LOCK_LOSS_COUNT_EN
    if (recorded && mCnt < 255) mCnt++;
`endif
    expq.push_back(expect_now());
    @(negedge clock);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check("async_reset", observed(), RST_OBS);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  always @(negedge clock)
    if (expq.size() > 0) check("cycle", observed(), expq.pop_front());

  initial begin
    obs_t sat;
    bus.pll_locked = 1'b0;
    bus.lost_clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check("reset_state", observed(), RST_OBS);
    reset = 1'b0;
    repeat (25) step(1, 0);
    do_reset();
    repeat (5) step(1, 0);
    step(0, 0);
    repeat (25) step(1, 0);
    step(0, 0);
    repeat (25) step(1, 0);
    step(0, 0);
    repeat (14) step(1, 0);
    step(0, 0);
    repeat (25) step(1, 0);
    step(0, 0);
    step(1, 0);
    step(1, 1);
    repeat (25) step(1, 0);
    step(1, 1);
    repeat (3) step(1, 0);
    repeat (2000) step($urandom_range(0, 31) != 0, $urandom_range(0, 15) == 0);
    repeat (300) begin
      repeat (12) step(1, $urandom_range(0, 7) == 0);
      step(0, 0);
    end
    repeat (3) step(1, 0);
    sat = observed();
    vectors++;
`ifdef LOCK_LOSS_COUNT_EN
    if (sat.cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL saturation: got count=%0d, required 255", sat.cnt);
    end
`else
    if (sat.cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL saturation: got count=%0d, required 0", sat.cnt);
    end
`endif
    repeat (12) step(1, 0);
    do_reset();
    repeat (25) step(1, 0);
    repeat (2) @(negedge clock);
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
